mod_exp_seq: RTL
================

# mod_exp_seq

Parametrised sequential modular-exponentiation engine computing `result = base^exponent mod modulus` with valid/ready handshakes on input and output. It is the next-generation exponentiation core behind the RSA `control` path. It generalises operand width to any `WIDTH`, adds back-pressure, adds operand error reporting, and offers an optional early-exit mode. Encryption and decryption differ only in the exponent supplied by the surrounding logic.

## Interface
- `WIDTH`, 128, operand width in bits; must be ≥ 4.
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands valid.
- `in_ready`  output  1  engine idle and able to accept operands.
- `base`  input  WIDTH  message or ciphertext; must be < `modulus`.
- `exponent`  input  WIDTH  e or d.
- `modulus`  input  WIDTH  n; must be ≥ 2.
- `out_valid`  output  1  `result` and `error` are valid.
- `out_ready`  input  1  consumer accepts the result.
- `result`  output  WIDTH  base^exponent mod modulus; 0 on error.
- `error`  output  1  operand violation (`modulus` < 2, or `base` ≥ `modulus`).
- `busy`  output  1  high in LOAD and MUL.

## Operation
- States: IDLE, LOAD, MUL, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`, register `base`, `exponent` and `modulus`, then go to LOAD.
  - Operand changes after the accept edge are ignored.
- **LOAD** (1 cycle)
  - On operand violation: `result`=0, `error`=1, go to DONE.
  - Otherwise initialise R=1, B=base, E=exponent and iteration counter N=0.
  - If the iteration count is zero, set `result`=1 and go to DONE (early-exit build only; see Configuration).
  - Otherwise go to MUL.
- **MUL**
  - Right-to-left square-and-multiply, one exponent bit per iteration.
  - Two bit-serial interleaved modular multipliers run in parallel:
    - RM computes R·B mod n.
    - SM computes B·B mod n.
  - Each multiplier runs WIDTH cycles, one multiplier bit per cycle, MSB first.
  - Per cycle: acc = 2·acc + (bit ? a : 0), followed by up to two conditional subtractions of n in the same cycle. Accumulator width is WIDTH+2. Invariant: acc < n at the end of every cycle.
  - On the last cycle of an iteration:
    - If E[0], R ← RM result; otherwise R is unchanged.
    - B ← SM result.
    - E ← E >> 1.
    - N increments.
  - Leave MUL when the iteration count is reached. On exit, `result` ← R and go to DONE.
- **DONE**
  - `out_valid`=1; `result` and `error` are held stable.
  - On `out_ready`, go to IDLE (`out_valid` falls and `in_ready` rises on the same edge).
  - `out_ready` asserted while `out_valid`=0 has no effect.
- A reset assertion in any state aborts immediately. Partial results are discarded and nothing is emitted.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0, `error`=0, `busy`=0. State is IDLE.
- Let the accept edge be t0. LOAD occupies t0→t0+1.
- Error case: `out_valid` is high after edge t0+1.
- Normal case: `out_valid` is high after edge t0+1+I·WIDTH, where I is the iteration count.
- Throughput: the next accept can occur no earlier than one cycle after the output handshake edge.
- `in_ready` and `out_valid` are never high together.

## Configuration
- Macro: `MOD_EXP_EARLY_EXIT_EN`.
- **Defined**
  - I = index of the highest set bit of `exponent` + 1.
  - `exponent`=0 gives I=0: LOAD sends the engine straight to DONE with `result`=1 after edge t0+1.
  - MUL exits when E becomes 0 after the shift.
  - Latency therefore leaks exponent length.
- **Undefined**
  - I = WIDTH always; latency is constant (1+WIDTH² cycles) regardless of exponent.
  - `exponent`=0 still yields `result`=1, after the full WIDTH iterations.

## Test plan
All scenarios use WIDTH=16.
- **Basic:** base=4, exponent=13, modulus=497 → `result`=445, `error`=0. Latency 1+4·16=65 cycles with `MOD_EXP_EARLY_EXIT_EN`; 257 cycles without.
- **RSA round trip:** n=3233. Encrypt base=65, exponent=17 → 2790. Feed 2790 back with exponent=2753 → 65.
- **Zero exponent:** base=7, exponent=0, modulus=11 → `result`=1. `out_valid` after edge t0+1 with the macro; after edge t0+257 without.
- **Errors:** modulus=1, base=0 → `error`=1, `result`=0. base=500, modulus=497 → `error`=1, `result`=0. Both report at t0+1.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles after `out_valid` rises. `result` stays stable and `in_ready` stays 0. Release → one handshake, then `in_ready`=1 on the next cycle.
- **Mid-operation reset:** pulse `reset_n` low during MUL. All outputs return to reset values asynchronously. A subsequent 4^13 mod 497 still gives 445.

Source files
------------

// File: rtl/mod_exp_seq.sv
// mod_exp_seq: sequential modular exponentiation, result = base^exponent mod modulus.
// Right-to-left square-and-multiply with two bit-serial interleaved modular
// multipliers (R*B and B*B) sharing the same multiplier bit stream (bits of B).
// Optional build macro MOD_EXP_EARLY_EXIT_EN: stop iterating once the remaining
// exponent is zero (latency then depends on exponent length).
module mod_exp_seq #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned IW = $clog2(WIDTH + 1);
    localparam int unsigned AW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] e_reg;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] rm_acc;
    logic [WIDTH-1:0] sm_acc;
    logic [CW-1:0]    bit_cnt;
    logic [IW-1:0]    iter_cnt;

    logic             op_err;
    logic             last_bit;
    logic             mul_exit;
    logic [CW-1:0]    bit_idx;
    logic             mul_bit;
    logic [WIDTH-1:0] rm_next;
    logic [WIDTH-1:0] sm_next;
    logic [WIDTH-1:0] r_upd;
    logic [WIDTH-1:0] e_shift;

    // One interleaved step: acc' = (2*acc + (sel ? a : 0)) mod n, given acc < n and a < n.
    // The sum is below 3n, so two conditional subtractions restore acc' < n.
    function automatic logic [WIDTH-1:0] mm_step(
        input logic [WIDTH-1:0] acc,
        input logic [WIDTH-1:0] a,
        input logic             sel,
        input logic [WIDTH-1:0] n
    );
        logic [AW-1:0] t;
        logic [AW-1:0] nn;
        nn = {2'b00, n};
        t  = {1'b0, acc, 1'b0} + (sel ? {2'b00, a} : '0);
        if (t >= nn) t = t - nn;
        if (t >= nn) t = t - nn;
        return t[WIDTH-1:0];
    endfunction

    assign op_err   = (n_reg < WIDTH'(2)) || (b_reg >= n_reg);
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));
    assign bit_idx  = CW'(WIDTH - 1) - bit_cnt;
    assign mul_bit  = b_reg[bit_idx];
    assign rm_next  = mm_step(rm_acc, r_reg, mul_bit, n_reg);
    assign sm_next  = mm_step(sm_acc, b_reg, mul_bit, n_reg);
    assign r_upd    = e_reg[0] ? rm_next : r_reg;
    assign e_shift  = e_reg >> 1;

`ifdef MOD_EXP_EARLY_EXIT_EN
    logic exp_zero;
    assign exp_zero = (e_reg == '0);
    // The iteration limit is redundant here (E is empty after WIDTH shifts) but bounds the loop.
    assign mul_exit = (e_shift == '0) || (iter_cnt == IW'(WIDTH - 1));
`else
    assign mul_exit = (iter_cnt == IW'(WIDTH - 1));
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state and handshake/status decode.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (op_err) state_next = DONE;
`ifdef MOD_EXP_EARLY_EXIT_EN
                else if (exp_zero) state_next = DONE;
`endif
                else state_next = MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (last_bit && mul_exit) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, multiplier accumulators, exponent walk and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_reg    <= '0;
            e_reg    <= '0;
            n_reg    <= '0;
            r_reg    <= '0;
            rm_acc   <= '0;
            sm_acc   <= '0;
            bit_cnt  <= '0;
            iter_cnt <= '0;
            result   <= '0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        b_reg <= base;
                        e_reg <= exponent;
                        n_reg <= modulus;
                    end
                end
                LOAD: begin
                    // B = base and E = exponent already sit in b_reg/e_reg from the accept edge.
                    if (op_err) begin
                        result <= '0;
                        error  <= 1'b1;
                    end else begin
                        error    <= 1'b0;
                        r_reg    <= WIDTH'(1);
                        rm_acc   <= '0;
                        sm_acc   <= '0;
                        bit_cnt  <= '0;
                        iter_cnt <= '0;
`ifdef MOD_EXP_EARLY_EXIT_EN
                        if (exp_zero) result <= WIDTH'(1);
`endif
                    end
                end
                MUL: begin
                    if (!last_bit) begin
                        rm_acc  <= rm_next;
                        sm_acc  <= sm_next;
                        bit_cnt <= bit_cnt + CW'(1);
                    end else begin
                        r_reg    <= r_upd;
                        b_reg    <= sm_next;
                        e_reg    <= e_shift;
                        iter_cnt <= iter_cnt + IW'(1);
                        rm_acc   <= '0;
                        sm_acc   <= '0;
                        bit_cnt  <= '0;
                        if (mul_exit) result <= r_upd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
